// File: rtl/rule_scheduler_pkg.sv
// Shared scheduler constants and types, reused by the system harness.
// Holds node count, starvation/deadlock limits and the LFSR seed/tap mask.
package rule_scheduler_pkg;

  localparam int SCHED_NODES        = 3;
  localparam int SCHED_STARVE_LIMIT = 7;
  localparam int SCHED_DEAD_LIMIT   = 4;

  localparam int WAIT_W = 3;
  localparam int STEP_W = 16;
  localparam int LFSR_W = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    SEL_ROUND_ROBIN = 1'b0,
    SEL_LFSR        = 1'b1
  } sel_mode_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v,
                                                  input logic [LFSR_W-1:0] taps);
    return {v[LFSR_W-2:0], ^(v & taps)};
  endfunction

endpackage

// File: rtl/rule_scheduler_if.sv
// Guard/enable bundle between the protocol system and the rule scheduler.
// master drives guards and controls; slave (the scheduler) returns grants and status.
interface rule_scheduler_if #(
  parameter int NODES = 3
);

  logic [NODES-1:0] io_guard;
  logic             io_hold;
  logic             io_mode;
  logic [NODES-1:0] io_en_a;
  logic             io_starve;
  logic             io_deadlock;
  logic [15:0]      io_step_count;

  modport master (
    output io_guard, io_hold, io_mode,
    input  io_en_a, io_starve, io_deadlock, io_step_count
  );

  modport slave (
    input  io_guard, io_hold, io_mode,
    output io_en_a, io_starve, io_deadlock, io_step_count
  );

endinterface

// File: rtl/rule_scheduler_lfsr.sv
// 8-bit Fibonacci LFSR used as the pseudo-random scan start.
// Value is registered; advances one step per enabled cycle, holds otherwise.
module sched_lfsr
  import rule_scheduler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED,
  parameter logic [LFSR_W-1:0] TAPS = LFSR_TAPS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_i,
  output logic [LFSR_W-1:0] value_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q, TAPS);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/rule_scheduler.sv
// One-hot rule scheduler: round-robin or LFSR-started scan with starvation override.
// Grant is combinational from guards (zero latency); io_hold stalls grants and freezes all state.
module rule_scheduler
  import rule_scheduler_pkg::*;
#(
  parameter int NODES        = SCHED_NODES,
  parameter int STARVE_LIMIT = SCHED_STARVE_LIMIT,
  parameter int DEAD_LIMIT   = SCHED_DEAD_LIMIT
) (
  input logic             clock,
  input logic             reset,
  rule_scheduler_if.slave bus
);

  localparam int PTR_W  = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int DEAD_W = $clog2(DEAD_LIMIT + 1);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_LIMIT);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NODES - 1);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WAIT_W-1:0] wait_q [NODES];
  logic [WAIT_W-1:0] wait_d [NODES];
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              deadlock_q, deadlock_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic              active;
  logic [LFSR_W-1:0] lfsr_val;
  logic [PTR_W-1:0]  start_idx;
  logic              starve_hit, rr_hit, grant_vld;
  logic [PTR_W-1:0]  starve_idx, rr_idx, grant_idx;
  logic [NODES-1:0]  en_a;

  assign active = !reset && !bus.io_hold;

  // Advances on every non-held cycle regardless of mode, so switching mode never flushes it.
  sched_lfsr #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .en_i    (active),
    .value_o (lfsr_val)
  );

  always_comb begin
    start_idx = ptr_q;
    if (sel_mode_e'(bus.io_mode) == SEL_LFSR) begin
      start_idx = PTR_W'(lfsr_val % LFSR_W'(NODES));
    end
  end

  // Both scans run downward so the lowest index / nearest offset is the last writer.
  always_comb begin : select
    logic [PTR_W:0] scan;
    scan       = '0;
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int k = NODES - 1; k >= 0; k--) begin
      if (bus.io_guard[k] && (wait_q[k] == WAIT_MAX)) begin
        starve_hit = 1'b1;
        starve_idx = PTR_W'(k);
      end
    end
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      scan = {1'b0, start_idx} + (PTR_W + 1)'(i);
      if (scan >= (PTR_W + 1)'(NODES)) begin
        scan = scan - (PTR_W + 1)'(NODES);
      end
      if (bus.io_guard[scan[PTR_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = scan[PTR_W-1:0];
      end
    end
  end

  assign grant_vld = active && (starve_hit || rr_hit);
  assign grant_idx = starve_hit ? starve_idx : rr_idx;
  assign en_a      = grant_vld ? (NODES'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d      = ptr_q;
    dead_d     = dead_q;
    deadlock_d = deadlock_q;
    step_d     = step_q;
    for (int k = 0; k < NODES; k++) begin
      wait_d[k] = wait_q[k];
    end
    if (active) begin
      for (int k = 0; k < NODES; k++) begin
        if (!bus.io_guard[k] || (grant_vld && (grant_idx == PTR_W'(k)))) begin
          wait_d[k] = '0;
        end else if (wait_q[k] != WAIT_MAX) begin
          wait_d[k] = wait_q[k] + 1'b1;
        end
      end
      if (grant_vld) begin
        ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        if (step_q != '1) begin
          step_d = step_q + 1'b1;
        end
      end
      if (bus.io_guard == '0) begin
        if (dead_q != DEAD_MAX) begin
          dead_d = dead_q + 1'b1;
        end
      end else begin
        dead_d = '0;
      end
      if (dead_d == DEAD_MAX) begin
        deadlock_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
      dead_q     <= '0;
      deadlock_q <= 1'b0;
      step_q     <= '0;
      for (int k = 0; k < NODES; k++) begin
        wait_q[k] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      dead_q     <= dead_d;
      deadlock_q <= deadlock_d;
      step_q     <= step_d;
      for (int k = 0; k < NODES; k++) begin
        wait_q[k] <= wait_d[k];
      end
    end
  end

  assign bus.io_en_a       = en_a;
  assign bus.io_starve     = active && starve_hit;
  assign bus.io_deadlock   = deadlock_q;
  assign bus.io_step_count = step_q;

endmodule
